// File: rtl/bpu_btb_ras.sv
`default_nettype none
// ============================================================================
// Module   : bpu_btb_ras
// Purpose  : Branch prediction unit. It combines a tagged, fully-associative
//            BTB holding a saturating direction counter per entry with a
//            circular return-address stack. The IFU looks up through the req_*
//            port and gets a registered response one cycle later on resp_*.
//            The EXU trains and allocates entries through upd_*. Call and
//            return tracking drives the RAS through ras_*.
// Ports    : clk, rstn (synchronous, active low)
//            req_valid/req_ready/req_pc          lookup request
//            resp_valid/hit/taken/idx/type/pc    registered lookup response
//            upd_valid/alloc/idx/taken/type/bp_pc/target  resolve/update
//            ras_valid/ras_op/ras_push_pc        RAS push/pop/pop-then-push
//            ras_count                           RAS occupancy 0..N_RAS_DEPTH
// Revision : 1.0  initial release
// ============================================================================
module bpu_btb_ras #(
  parameter int N_ADDR_BITS = 32,
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 8,
  parameter int N_CNT_BITS  = 2,
  parameter int N_RAS_DEPTH = 4,
  parameter int N_IDX_W     = $clog2(N_ENTRIES),
  parameter int N_RAS_W     = $clog2(N_RAS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N_ADDR_BITS-1:0] req_pc,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_taken,
  output logic [N_IDX_W-1:0]     resp_idx,
  output logic [1:0]             resp_type,
  output logic [N_DATA_BITS-1:0] resp_pc,
  input  logic                   upd_valid,
  input  logic                   upd_alloc,
  input  logic [N_IDX_W-1:0]     upd_idx,
  input  logic                   upd_taken,
  input  logic [1:0]             upd_type,
  input  logic [N_ADDR_BITS-1:0] upd_bp_pc,
  input  logic [N_DATA_BITS-1:0] upd_target,
  input  logic                   ras_valid,
  input  logic [1:0]             ras_op,
  input  logic [N_DATA_BITS-1:0] ras_push_pc,
  output logic [N_RAS_W:0]       ras_count
);

  localparam logic [1:0] c_type_bra = 2'b00;
  localparam logic [1:0] c_type_ret = 2'b11;
  localparam logic [1:0] c_op_push  = 2'b00;
  localparam logic [1:0] c_op_pop   = 2'b01;
  localparam logic [1:0] c_op_pp    = 2'b10;
  localparam logic [N_CNT_BITS-1:0] c_cnt_max = {N_CNT_BITS{1'b1}};
  localparam logic [N_CNT_BITS-1:0] c_cnt_wt  = {1'b1, {(N_CNT_BITS-1){1'b0}}};
  localparam logic [N_CNT_BITS-1:0] c_cnt_wnt = {1'b0, {(N_CNT_BITS-1){1'b1}}};
  localparam logic [N_RAS_W:0]      c_ras_full = (N_RAS_W+1)'(N_RAS_DEPTH);

  // BTB storage
  logic                   r_valid [N_ENTRIES];
  logic [N_ADDR_BITS-1:0] r_tag   [N_ENTRIES];
  logic [N_DATA_BITS-1:0] r_tgt   [N_ENTRIES];
  logic [1:0]             r_type  [N_ENTRIES];
  logic [N_CNT_BITS-1:0]  r_cnt   [N_ENTRIES];
  logic [N_IDX_W-1:0]     r_rr;

  // RAS storage
  logic [N_DATA_BITS-1:0] r_ras [N_RAS_DEPTH];
  logic [N_RAS_W-1:0]     r_tos;
  logic [N_RAS_W:0]       r_ras_cnt;

  // Response registers
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_resp_hit;
  logic                   r_resp_taken;
  logic [N_IDX_W-1:0]     r_resp_idx;
  logic [1:0]             r_resp_type;
  logic [N_DATA_BITS-1:0] r_resp_pc;

  logic                   w_accept;
  logic                   w_hit;
  logic [N_IDX_W-1:0]     w_hit_idx;
  logic                   w_amatch;
  logic [N_IDX_W-1:0]     w_amatch_idx;
  logic                   w_has_inv;
  logic [N_IDX_W-1:0]     w_inv_idx;
  logic [N_IDX_W-1:0]     w_upd_idx;
  logic                   w_upd_new;
  logic                   w_use_rr;
  logic [N_CNT_BITS-1:0]  w_cnt_cur;
  logic [N_CNT_BITS-1:0]  w_cnt_next;
  logic [N_RAS_W-1:0]     w_tos_m1;
  logic [N_DATA_BITS-1:0] w_lk_pc;
  logic                   w_lk_taken;

  assign w_accept = req_valid && r_req_ready;
  assign w_tos_m1 = r_tos - 1'b1;

  // Tag search for the lookup port, the allocation dedup search, and the
  // lowest-index free slot (scanned from the top so the lowest one wins).
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_amatch     = 1'b0;
    w_amatch_idx = '0;
    w_has_inv    = 1'b0;
    w_inv_idx    = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == req_pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = N_IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == upd_bp_pc)) begin
        w_amatch     = 1'b1;
        w_amatch_idx = N_IDX_W'(i);
      end
    end
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_inv = 1'b1;
        w_inv_idx = N_IDX_W'(i);
      end
    end
  end

  // Choose the entry written by the update port and whether it is a fresh
  // allocation (new tag) or a training update of an existing entry.
  always_comb begin
    w_upd_idx = upd_idx;
    w_upd_new = 1'b0;
    w_use_rr  = 1'b0;
    if (upd_alloc) begin
      if (w_amatch) begin
        w_upd_idx = w_amatch_idx;
      end else if (w_has_inv) begin
        w_upd_idx = w_inv_idx;
        w_upd_new = 1'b1;
      end else begin
        w_upd_idx = r_rr;
        w_upd_new = 1'b1;
        w_use_rr  = 1'b1;
      end
    end
    w_cnt_cur  = r_cnt[w_upd_idx];
    w_cnt_next = w_cnt_cur;
    if (upd_taken) begin
      if (w_cnt_cur != c_cnt_max) w_cnt_next = w_cnt_cur + 1'b1;
    end else begin
      if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - 1'b1;
    end
  end

  // Lookup result from pre-edge state; returns fall back to the stored
  // target when the RAS is empty.
  always_comb begin
    w_lk_pc    = '0;
    w_lk_taken = 1'b0;
    if (w_hit) begin
      w_lk_taken = r_cnt[w_hit_idx][N_CNT_BITS-1] || (r_type[w_hit_idx] != c_type_bra);
      if ((r_type[w_hit_idx] == c_type_ret) && (r_ras_cnt != '0)) w_lk_pc = r_ras[w_tos_m1];
      else                                                         w_lk_pc = r_tgt[w_hit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_taken <= 1'b0;
      r_resp_idx   <= '0;
      r_resp_type  <= '0;
      r_resp_pc    <= '0;
      r_rr         <= '0;
      r_tos        <= '0;
      r_ras_cnt    <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_type[i]  <= '0;
        r_cnt[i]   <= '0;
      end
      for (int i = 0; i < N_RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= w_accept;
      r_resp_hit   <= w_accept && w_hit;
      r_resp_taken <= w_accept && w_lk_taken;
      r_resp_idx   <= w_accept ? w_hit_idx : '0;
      r_resp_type  <= (w_accept && w_hit) ? r_type[w_hit_idx] : 2'b00;
      r_resp_pc    <= w_accept ? w_lk_pc : '0;

      if (upd_valid) begin
        r_tgt[w_upd_idx]  <= upd_target;
        r_type[w_upd_idx] <= upd_type;
        if (w_upd_new) begin
          r_valid[w_upd_idx] <= 1'b1;
          r_tag[w_upd_idx]   <= upd_bp_pc;
          r_cnt[w_upd_idx]   <= upd_taken ? c_cnt_wt : c_cnt_wnt;
        end else begin
          r_cnt[w_upd_idx] <= w_cnt_next;
        end
        if (w_use_rr) r_rr <= r_rr + 1'b1;
      end

      if (ras_valid) begin
        // Pop-then-push on an empty stack degenerates to a plain push.
        if ((ras_op == c_op_push) || ((ras_op == c_op_pp) && (r_ras_cnt == '0))) begin
          r_ras[r_tos] <= ras_push_pc;
          r_tos        <= r_tos + 1'b1;
          if (r_ras_cnt != c_ras_full) r_ras_cnt <= r_ras_cnt + 1'b1;
        end else if (ras_op == c_op_pop) begin
          if (r_ras_cnt != '0) begin
            r_tos     <= w_tos_m1;
            r_ras_cnt <= r_ras_cnt - 1'b1;
          end
        end else if (ras_op == c_op_pp) begin
          r_ras[w_tos_m1] <= ras_push_pc;
        end
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_taken = r_resp_taken;
  assign resp_idx   = r_resp_idx;
  assign resp_type  = r_resp_type;
  assign resp_pc    = r_resp_pc;
  assign ras_count  = r_ras_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bpu_btb_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_btb_ras
// Purpose  : Directed, self-checking bench for bpu_btb_ras with hand-computed
//            expected values (8-entry BTB, 2-bit counters, 4-deep RAS).
// Revision : 1.0  initial release
// ============================================================================
module tb_bpu_btb_ras;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_taken;
  logic [2:0]  resp_idx;
  logic [1:0]  resp_type;
  logic [31:0] resp_pc;
  logic        upd_valid;
  logic        upd_alloc;
  logic [2:0]  upd_idx;
  logic        upd_taken;
  logic [1:0]  upd_type;
  logic [31:0] upd_bp_pc;
  logic [31:0] upd_target;
  logic        ras_valid;
  logic [1:0]  ras_op;
  logic [31:0] ras_push_pc;
  logic [2:0]  ras_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bpu_btb_ras dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_taken (resp_taken),
    .resp_idx   (resp_idx),
    .resp_type  (resp_type),
    .resp_pc    (resp_pc),
    .upd_valid  (upd_valid),
    .upd_alloc  (upd_alloc),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_type   (upd_type),
    .upd_bp_pc  (upd_bp_pc),
    .upd_target (upd_target),
    .ras_valid  (ras_valid),
    .ras_op     (ras_op),
    .ras_push_pc(ras_push_pc),
    .ras_count  (ras_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
    req_pc    = '0;
  endtask

  task automatic check_resp(input string tag, input logic hit, input logic taken,
                            input logic [2:0] idx, input logic [1:0] typ, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".hit"},   32'(resp_hit),   32'(hit));
    check({tag, ".taken"}, 32'(resp_taken), 32'(taken));
    check({tag, ".idx"},   32'(resp_idx),   32'(idx));
    check({tag, ".type"},  32'(resp_type),  32'(typ));
    check({tag, ".pc"},    resp_pc,         pc);
  endtask

  task automatic set_upd(input logic alloc, input logic [2:0] idx, input logic tk,
                         input logic [1:0] typ, input logic [31:0] pc, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_alloc  = alloc;
    upd_idx    = idx;
    upd_taken  = tk;
    upd_type   = typ;
    upd_bp_pc  = pc;
    upd_target = tgt;
  endtask

  task automatic clr_upd();
    upd_valid = 1'b0; upd_alloc = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    upd_type = '0; upd_bp_pc = '0; upd_target = '0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ, input logic tk);
    set_upd(1'b1, 3'd0, tk, typ, pc, tgt);
    tick();
    clr_upd();
  endtask

  task automatic update(input logic [2:0] idx, input logic tk, input logic [1:0] typ, input logic [31:0] tgt);
    set_upd(1'b0, idx, tk, typ, 32'h0, tgt);
    tick();
    clr_upd();
  endtask

  task automatic ras(input logic [1:0] op, input logic [31:0] pc);
    ras_valid   = 1'b1;
    ras_op      = op;
    ras_push_pc = pc;
    tick();
    ras_valid   = 1'b0;
    ras_op      = 2'b11;
    ras_push_pc = '0;
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_pc = '0;
    ras_valid = 1'b0; ras_op = 2'b11; ras_push_pc = '0;
    clr_upd();

    // Reset and release
    repeat (3) tick();
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.rvalid", 32'(resp_valid), 32'd0);
    check("rst.rascnt", 32'(ras_count), 32'd0);
    rstn = 1'b1;
    check("rel.ready_pre", 32'(req_ready), 32'd0);
    tick();
    check("rel.ready_post", 32'(req_ready), 32'd1);

    // Cold miss, then response drops to zero next cycle
    lookup(32'h1234);
    check_resp("miss", 1'b0, 1'b0, 3'd0, 2'b00, 32'h0);
    tick();
    check("idle.rvalid", 32'(resp_valid), 32'd0);
    check("idle.pc", resp_pc, 32'h0);

    // Allocate BRA taken, then train down twice
    alloc(32'h100, 32'h200, 2'b00, 1'b1);
    lookup(32'h100);
    check_resp("bra_wt", 1'b1, 1'b1, 3'd0, 2'b00, 32'h200);
    update(3'd0, 1'b0, 2'b00, 32'h200);
    update(3'd0, 1'b0, 2'b00, 32'h200);
    lookup(32'h100);
    check_resp("bra_snt", 1'b1, 1'b0, 3'd0, 2'b00, 32'h200);

    // Fill entries 1..7, then 9th PC evicts entry 0 via round robin
    for (int k = 1; k < 8; k++) alloc(32'h100 + 32'(4*k), 32'h200 + 32'(4*k), 2'b00, 1'b1);
    alloc(32'h300, 32'h3000, 2'b00, 1'b1);
    lookup(32'h100);
    check("evict.old_hit", 32'(resp_hit), 32'd0);
    lookup(32'h300);
    check_resp("evict.new", 1'b1, 1'b1, 3'd0, 2'b00, 32'h3000);

    // Re-alloc existing PC updates in place (counter 10 -> 11), rr untouched
    alloc(32'h104, 32'h555, 2'b01, 1'b1);
    lookup(32'h104);
    check_resp("dedup", 1'b1, 1'b1, 3'd1, 2'b01, 32'h555);
    alloc(32'h400, 32'h4000, 2'b00, 1'b0);
    lookup(32'h400);
    check_resp("rr1", 1'b1, 1'b0, 3'd1, 2'b00, 32'h4000);
    lookup(32'h108);
    check_resp("keep2", 1'b1, 1'b1, 3'd2, 2'b00, 32'h208);

    // RET entry goes to rr slot 2; RAS push overflow
    alloc(32'h500, 32'hABC, 2'b11, 1'b0);
    ras(2'b00, 32'h10); ras(2'b00, 32'h20); ras(2'b00, 32'h30);
    ras(2'b00, 32'h40); ras(2'b00, 32'h50);
    check("ras.full", 32'(ras_count), 32'd4);
    lookup(32'h500);
    check_resp("ret50", 1'b1, 1'b1, 3'd2, 2'b11, 32'h50);
    ras(2'b01, 32'h0);
    lookup(32'h500);
    check("ret40", resp_pc, 32'h40);
    ras(2'b01, 32'h0);
    lookup(32'h500);
    check("ret30", resp_pc, 32'h30);
    ras(2'b01, 32'h0);
    lookup(32'h500);
    check("ret20", resp_pc, 32'h20);
    ras(2'b01, 32'h0);
    check("ras.empty", 32'(ras_count), 32'd0);
    ras(2'b01, 32'h0);
    check("ras.pop_empty", 32'(ras_count), 32'd0);
    lookup(32'h500);
    check("ret_stored", resp_pc, 32'hABC);

    // Pop-then-push on count 2
    ras(2'b00, 32'h61); ras(2'b00, 32'h62);
    ras(2'b10, 32'h77);
    check("pp.count", 32'(ras_count), 32'd2);
    lookup(32'h500);
    check("pp.top", resp_pc, 32'h77);

    // Same-edge update of entry 3 and lookup hitting entry 3
    set_upd(1'b0, 3'd3, 1'b0, 2'b00, 32'h0, 32'h999);
    lookup(32'h10C);
    clr_upd();
    check_resp("rbw.pre", 1'b1, 1'b1, 3'd3, 2'b00, 32'h20C);
    lookup(32'h10C);
    check_resp("rbw.post", 1'b1, 1'b0, 3'd3, 2'b00, 32'h999);

    // Reset asserted with a lookup in flight
    rstn = 1'b0;
    lookup(32'h300);
    check("mrst.rvalid", 32'(resp_valid), 32'd0);
    check("mrst.ready", 32'(req_ready), 32'd0);
    check("mrst.rascnt", 32'(ras_count), 32'd0);
    rstn = 1'b1;
    tick();
    lookup(32'h300);
    check_resp("mrst.miss", 1'b0, 1'b0, 3'd0, 2'b00, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
